// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the word-to-byte UART transmit stage:
// serialiser state encoding and helpers deriving byte counts from the word width.
package uart_word_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_t;

    function automatic int nbytes_f(input int n);
        return n / 8;
    endfunction

    // A single-byte word still needs a 1-bit index register.
    function automatic int byte_idx_w_f(input int n);
        return ((n / 8) > 1) ? $clog2(n / 8) : 1;
    endfunction

endpackage

// File: rtl/uart_word_tx_sync_word_fifo.sv
// Synchronous word FIFO with registered occupancy count; a push is refused when full
// and a pop is ignored when empty, so push and pop may coincide freely.
module sync_word_fifo #(
    parameter int W  = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap modulo depth; the count tracks occupancy independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Buffers N-bit words and feeds them MSB byte first to a UART, pacing on its busy flag
// and re-pulsing a byte the UART failed to pick up.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int N          = 16,
    parameter int DEPTH_LOG2 = 2,
    parameter int START_TO   = 4
) (
    input  logic                  iCE_CLK,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [N-1:0]          rx_bytes,
    output logic                  rx_ready,
    input  logic                  is_transmitting,
    output logic [7:0]            tx_byte,
    output logic                  tx_valid,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  busy,
    output logic                  overflow
);
    localparam int NBYTES = nbytes_f(N);
    localparam int BIW    = byte_idx_w_f(N);
    localparam int TW     = $clog2(START_TO) + 1;
    // The pulse cycle counts as the first wait cycle, so the re-pulse lands START_TO cycles after it.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TO - 2);

    tx_state_t        state_r;
    logic [N-1:0]     shift_r;
    logic [BIW-1:0]   byte_idx_r;
    logic [TW-1:0]    timer_r;
    logic [7:0]       tx_byte_r;
    logic             tx_valid_r;
    logic             overflow_r;
    logic [N-1:0]     fifo_rdata_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;

    sync_word_fifo #(
        .W  (N),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk   (iCE_CLK),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (pop_s),
        .wdata (rx_bytes),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    // Never start a word while the UART is still busy, e.g. straight after a reset.
    assign pop_s    = (state_r == ST_IDLE) & ~fifo_empty_s & ~is_transmitting;
    assign rx_ready = ~fifo_full_s;
    assign busy     = (state_r != ST_IDLE) | (fifo_count != {(DEPTH_LOG2+1){1'b0}});
    assign tx_byte  = tx_byte_r;
    assign tx_valid = tx_valid_r;
    assign overflow = overflow_r;

    // Sticky flag for words offered while the FIFO was full.
    always_ff @(posedge iCE_CLK) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (rx_valid & fifo_full_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Serialiser: one pulse per byte, wait for the UART to go busy and then idle again.
    always_ff @(posedge iCE_CLK) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {N{1'b0}};
            byte_idx_r <= {BIW{1'b0}};
            timer_r    <= {TW{1'b0}};
            tx_byte_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            tx_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r    <= fifo_rdata_s;
                        byte_idx_r <= BIW'(NBYTES - 1);
                        state_r    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_byte_r  <= shift_r[8*byte_idx_r +: 8];
                    tx_valid_r <= 1'b1;
                    timer_r    <= {TW{1'b0}};
                    state_r    <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (is_transmitting) begin
                        state_r <= ST_WAIT_LO;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_r <= ST_SEND;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!is_transmitting) begin
                        if (byte_idx_r == {BIW{1'b0}}) begin
                            state_r <= ST_IDLE;
                        end else begin
                            byte_idx_r <= byte_idx_r - BIW'(1);
                            state_r    <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomised scoreboard bench for uart_word_tx with a simple UART busy-flag model.
module tb_uart_word_tx;
    localparam int N      = 16;
    localparam int DL     = 2;
    localparam int ST_TO  = 4;
    // Pulse-to-pulse spacing with the UART model: 1 cycle to raise, 10 busy, 1 to sample the fall, 1 to pulse.
    localparam int GAP    = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [N-1:0]  rx_bytes;
    logic          rx_ready;
    logic          is_tx;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic [DL:0]   fifo_count;
    logic          busy;
    logic          overflow;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            last_push_cyc = 0;
    logic [7:0]    exp_q [$];
    int            pulse_cyc [$];
    bit            hold_busy = 1'b0;
    bit            uart_busy = 1'b0;
    bit            pend = 1'b0;
    int            busy_cnt = 0;
    int            ignore_n = 0;
    bit            prev_valid = 1'b0;
    logic [N-1:0]  t2w [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    assign is_tx = hold_busy | uart_busy;

    always #5 clk = ~clk;

    uart_word_tx #(.N(N), .DEPTH_LOG2(DL), .START_TO(ST_TO)) dut (
        .iCE_CLK         (clk),
        .rst             (rst),
        .rx_valid        (rx_valid),
        .rx_bytes        (rx_bytes),
        .rx_ready        (rx_ready),
        .is_transmitting (is_tx),
        .tx_byte         (tx_byte),
        .tx_valid        (tx_valid),
        .fifo_count      (fifo_count),
        .busy            (busy),
        .overflow        (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every pulse must match the next expected byte.
    initial forever begin
        @(negedge clk);
        if (tx_valid) begin
            check("no_back_to_back", {31'b0, prev_valid}, 32'd0);
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got byte %0h expected none", tx_byte);
            end else begin
                check("tx_byte", {24'b0, tx_byte}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_valid = tx_valid;
    end

    // UART model: busy for 10 cycles starting one cycle after an accepted pulse.
    initial forever begin
        @(negedge clk);
        if (tx_valid) check("pulse_while_busy", {31'b0, is_tx}, 32'd0);
        if (pend) begin
            pend = 1'b0;
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (tx_valid) begin
            if (ignore_n > 0) ignore_n--;
            else pend = 1'b1;
        end
        uart_busy = (busy_cnt > 0);
    end

    task automatic push_word(input logic [N-1:0] w);
        int t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_bytes = w;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            rx_valid = 1'b0;
            fail_now("push_wait");
        end else begin
            last_push_cyc = cyc + 1;
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || is_tx || pend) && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 3000) fail_now(name);
        repeat (2) @(negedge clk);
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
        check({name, "_count"}, {29'b0, fifo_count}, 32'd0);
    endtask

    initial begin
        int n0;
        int t;
        logic [N-1:0] w;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_bytes = '0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
        check("rst_count", {29'b0, fifo_count}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        rst = 1'b0;

        // T1: single word, latency and spacing
        pulse_cyc.delete();
        push_word(16'hA55A);
        @(negedge clk);
        check("t1_count", {29'b0, fifo_count}, 32'd1);
        check("t1_busy", {31'b0, busy}, 32'd1);
        wait_drain("t1");
        check("t1_npulse", pulse_cyc.size(), 32'd2);
        if (pulse_cyc.size() == 2) begin
            check("t1_latency", pulse_cyc[0] - last_push_cyc, 32'd2);
            check("t1_gap", pulse_cyc[1] - pulse_cyc[0], GAP);
        end

        // T2: overfill while the UART is held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_bytes = t2w[i];
            check("t2_rx_ready", {31'b0, rx_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) begin
                exp_q.push_back(t2w[i][15:8]);
                exp_q.push_back(t2w[i][7:0]);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("t2_overflow", {31'b0, overflow}, 32'd1);
        check("t2_count", {29'b0, fifo_count}, 32'd4);
        hold_busy = 1'b0;
        wait_drain("t2");
        check("t2_overflow_sticky", {31'b0, overflow}, 32'd1);

        // T3: first pulse ignored by the UART
        pulse_cyc.delete();
        ignore_n = 1;
        exp_q.push_back(8'hC3);
        push_word(16'hC3E1);
        wait_drain("t3");
        check("t3_npulse", pulse_cyc.size(), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("t3_repulse", pulse_cyc[1] - pulse_cyc[0], ST_TO);
            check("t3_gap", pulse_cyc[2] - pulse_cyc[1], GAP);
        end

        // T4: reset in WAIT_LO of the first byte
        push_word(16'h1234);
        push_word(16'h5678);
        t = 0;
        while (!is_tx && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!is_tx) fail_now("t4_wait_busy");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        hold_busy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("t4_tx_byte", {24'b0, tx_byte}, 32'd0);
        check("t4_count", {29'b0, fifo_count}, 32'd0);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_overflow", {31'b0, overflow}, 32'd0);
        check("t4_rx_ready", {31'b0, rx_ready}, 32'd1);
        n0 = pulse_cyc.size();
        push_word(16'h9ABC);
        repeat (6) @(negedge clk);
        check("t4_no_pulse_busy", pulse_cyc.size(), n0);
        hold_busy = 1'b0;
        wait_drain("t4");

        // T5: push and pop in the same cycle with two words queued
        hold_busy = 1'b1;
        push_word(16'h0102);
        push_word(16'h0304);
        @(negedge clk);
        check("t5_count_pre", {29'b0, fifo_count}, 32'd2);
        hold_busy = 1'b0;
        rx_valid = 1'b1;
        rx_bytes = 16'h0506;
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h06);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        check("t5_count_same", {29'b0, fifo_count}, 32'd2);
        wait_drain("t5");

        // T6: random words through the wrapping FIFO
        n0 = pulse_cyc.size();
        for (int i = 0; i < 10; i++) begin
            w = N'($urandom);
            push_word(w);
        end
        wait_drain("t6");
        check("t6_npulse", pulse_cyc.size() - n0, 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
